// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned multiplier with valid/ready handshakes on both sides.
// Define SEQ_MULT_RADIX4_EN for radix-4 Booth recoding (two multiplier bits per cycle).
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

`ifdef SEQ_MULT_RADIX4_EN
  localparam int STEP = 2;
  localparam int MW   = WIDTH + 1;
`else
  localparam int STEP = 1;
  localparam int MW   = WIDTH;
`endif
  localparam int STEPS = WIDTH / STEP;
  localparam int PW    = 2 * WIDTH;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   mcand_q;
  logic [MW-1:0]   mplier_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   prod_q;
  logic [CW-1:0]   cnt_q;
  logic            signed_q;
  logic            out_valid_q;
  logic            in_ready_q;
  logic            busy_q;

  logic [PW-1:0]   a_ext_s;
  logic [PW-1:0]   acc_init_s;
  logic [MW-1:0]   mplier_init_s;
  logic [PW-1:0]   pp_s;
  logic            sub_s;
  logic [PW-1:0]   mcand_d;
  logic [MW-1:0]   mplier_d;
  logic [PW-1:0]   acc_d;

  // Operand preparation at accept: multiplicand extended to full product width.
  always_comb begin
    a_ext_s = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
`ifdef SEQ_MULT_RADIX4_EN
    mplier_init_s = {in_b, 1'b0};
    // Booth treats b as signed; an unsigned b with its MSB set is short by a*2^WIDTH.
    if (!in_signed && in_b[WIDTH-1]) begin
      acc_init_s = {in_a, {WIDTH{1'b0}}};
    end else begin
      acc_init_s = '0;
    end
`else
    mplier_init_s = in_b;
    acc_init_s    = '0;
`endif
  end

  // One multiplier step: select partial product and add or subtract it.
  always_comb begin
    pp_s  = '0;
    sub_s = 1'b0;
`ifdef SEQ_MULT_RADIX4_EN
    case (mplier_q[2:0])
      3'b001, 3'b010: begin pp_s = mcand_q;        sub_s = 1'b0; end
      3'b011:         begin pp_s = mcand_q << 1;   sub_s = 1'b0; end
      3'b100:         begin pp_s = mcand_q << 1;   sub_s = 1'b1; end
      3'b101, 3'b110: begin pp_s = mcand_q;        sub_s = 1'b1; end
      default:        begin pp_s = '0;             sub_s = 1'b0; end
    endcase
    mcand_d  = mcand_q << 2;
    mplier_d = mplier_q >> 2;
`else
    if (mplier_q[0]) begin
      pp_s = mcand_q;
    end else begin
      pp_s = '0;
    end
    // The signed MSB of b carries negative weight.
    sub_s    = signed_q && (cnt_q == LAST);
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
`endif
    if (sub_s) begin
      acc_d = acc_q - pp_s;
    end else begin
      acc_d = acc_q + pp_s;
    end
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= a_ext_s;
            mplier_q   <= mplier_init_s;
            acc_q      <= acc_init_s;
            signed_q   <= in_signed;
            cnt_q      <= '0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          acc_q    <= acc_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            prod_q      <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_product = prod_q;
  assign busy        = busy_q;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values even and >= 4.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  operands and mode present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port in_a  input  WIDTH  multiplicand.
REQ-007 SHALL have port in_b  input  WIDTH  multiplier.
REQ-008 SHALL have port in_signed  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-009 SHALL have port out_valid  output  1  out_product holds a finished result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_product  output  2*WIDTH  full-width product.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE in a registered FSM.
REQ-014 in_ready SHALL equal (state == IDLE), with no combinational path from in_valid.
REQ-015 Accept SHALL occur on a clock edge where in_valid and in_ready are both 1; that edge SHALL latch in_a, in_b and in_signed, clear the step counter and enter CALC.
REQ-016 CALC SHALL retire STEP multiplier bits per cycle (STEP = 1 by default, 2 under REQ-030), with STEPS = WIDTH/STEP cycles in CALC.
REQ-017 out_valid SHALL rise exactly STEPS cycles after the accepting edge: 16 cycles for WIDTH = 16 radix-2.
REQ-018 In DONE, out_valid SHALL be 1 and out_product SHALL hold the exact product: the signed product of in_a*in_b when in_signed = 1, the unsigned product otherwise, with no truncation or overflow for any operand pair.
REQ-019 out_product and out_valid SHALL stay stable in DONE until out_ready = 1; the edge with out_valid & out_ready SHALL return the FSM to IDLE.
REQ-020 in_valid SHALL be ignored in CALC and DONE; operand or mode changes after accept SHALL NOT affect the result in flight.
REQ-021 Back-to-back operation SHALL give a minimum issue interval of STEPS+2 cycles (accept, STEPS-1 CALC, DONE, IDLE).
REQ-022 Corner operands SHALL be exact: signed most-negative x most-negative, unsigned all-ones x all-ones, and zero x any.
REQ-023 out_product SHALL read 0 while out_valid = 0 after reset, and SHALL retain the last result in IDLE after a handshake.

Reset
REQ-024 With rst = 1 at a clock edge, state SHALL become IDLE, and out_valid = 0, out_product = 0, busy = 0 and in_ready = 1 on the following cycle.
REQ-025 rst in CALC or DONE SHALL abandon the operation silently, with no out_valid pulse.
REQ-026 rst SHALL take priority over a simultaneous accept or output handshake.
REQ-027 All internal registers (operands, accumulator, counter, mode) SHALL be cleared by rst.

Configuration
REQ-028 SHALL use the macro SEQ_MULT_RADIX4_EN.
REQ-029 With SEQ_MULT_RADIX4_EN undefined: radix-2 operation, STEP = 1, STEPS = WIDTH.
REQ-030 With SEQ_MULT_RADIX4_EN defined: radix-4 Booth recoding, STEP = 2, STEPS = WIDTH/2; results SHALL be identical to radix-2 for all inputs and modes.

Verification
REQ-031 WIDTH=16, signed, a=0x8000, b=0x8000 -> out_product=0x4000_0000 with out_valid 16 cycles after accept (8 with SEQ_MULT_RADIX4_EN).
REQ-032 Signed, a=0x0003, b=0xFFFB -> 0xFFFF_FFF1; unsigned, a=0xFFFF, b=0xFFFF -> 0xFFFE_0001.
REQ-033 Signed, a=0xFFFF, b=0x0001 -> 0xFFFF_FFFF; same operands unsigned -> 0x0000_FFFF.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid/in_a -> out_valid and out_product unchanged, in_ready=0, second operation not accepted until one cycle after the handshake.
REQ-035 Assert rst for 1 cycle at CALC cycle 5 -> next cycle state IDLE, in_ready=1, out_valid=0, out_product=0; a fresh 7x9 unsigned operation then yields 0x0000_003F.
REQ-036 Random signed/unsigned operands for WIDTH in {4,16,32}, back-to-back with out_ready tied high -> every result matches the reference model, issue interval = STEPS+2.
